// File: rtl/dpram_arbiter_pkg.sv
// Shared definitions for the dual-port RAM data-port arbiter: master ids,
// lock FSM encoding and default bus widths.
package dpram_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  // Master identifiers, also the encoding of the last-winner register.
  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

  // ARB: plain round-robin. LOCK: M1 holds the port for a locked burst.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage : dpram_arbiter_pkg

// File: rtl/dpram_arbiter_rr_arb2.sv
// Two-way round-robin picker. With both requesting, the master that did not
// win last time gets the grant; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // Pick a winner from the request vector and the previous winner.
  always_comb begin
    // NOTE: every output of a combinational block is assigned a default
    // before any branch so no path can leave it unassigned and infer a latch.
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule : rr_arb2

// File: rtl/dpram_arbiter.sv
// Data-port arbiter for the dual-port RAM: M0 (CPU LSU) and M1 (debug /
// loader DMA) share one port. Round-robin per cycle, with M1 allowed to hold
// a locked burst that is forcibly broken after MAX_LOCK beats if M0 waits.
// Grants are combinational; read data comes back registered one cycle later.
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_LOCK   = 8,
  parameter int LOCK_CNT_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,

  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic                  m1_lock_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,

  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic                  busy_o
);

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);
  localparam logic [LOCK_CNT_W-1:0] ONE_C      = LOCK_CNT_W'(1);

  arb_state_e            state_q, state_d;
  logic                  last_winner_q, last_winner_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic                  m0_rvalid_q, m1_rvalid_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

  logic [1:0]            rr_gnt;
  logic                  m0_win, m1_win;
  logic                  lock_hold;
  logic                  m0_rd, m1_rd;

  rr_arb2 u_rr_arb2 (
    .req_i  ({m1_req_i, m0_req_i}),
    .last_i (last_winner_q),
    .gnt_o  (rr_gnt)
  );

  // M1 keeps asking for the port as part of a locked burst.
  assign lock_hold = m1_req_i & m1_lock_i;

  // Choose this cycle's winner. In LOCK, M1 keeps the port until it lets go
  // or until the beat cap is hit while M0 waits; otherwise round-robin.
  always_comb begin
    m0_win = 1'b0;
    m1_win = 1'b0;
    if (rst_ni) begin
      if (state_q == LOCK && lock_hold) begin
        if (lock_cnt_q < MAX_LOCK_C || !m0_req_i) begin
          m1_win = 1'b1;
        end else begin
          m0_win = 1'b1;
        end
      end else begin
        m0_win = rr_gnt[MASTER_M0];
        m1_win = rr_gnt[MASTER_M1];
      end
    end
  end

  // Next-state for the lock FSM, beat counter and round-robin pointer.
  always_comb begin
    state_d       = ARB;
    lock_cnt_d    = '0;
    last_winner_d = last_winner_q;
    if (m0_win) last_winner_d = MASTER_M0;
    if (m1_win) last_winner_d = MASTER_M1;
    if (m1_win && m1_lock_i) begin
      state_d = LOCK;
      if (state_q == LOCK) begin
        lock_cnt_d = (lock_cnt_q == MAX_LOCK_C) ? lock_cnt_q : lock_cnt_q + ONE_C;
      end else begin
        lock_cnt_d = ONE_C;
      end
    end
  end

  // Lock FSM state register; reset aborts any lock and favours M0 first.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_ni) begin
      state_q       <= ARB;
      last_winner_q <= MASTER_M1;
      lock_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  assign m0_rd = m0_win & ~m0_we_i;
  assign m1_rd = m1_win & ~m1_we_i;

  // Capture read data for the granted reader; rdata holds between reads.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_rd;
      m1_rvalid_q <= m1_rd;
      if (m0_rd) m0_rdata_q <= mem_rdata_i;
      if (m1_rd) m1_rdata_q <= mem_rdata_i;
    end
  end

  // Steer the RAM port from the winner; an idle port is driven to zero.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (m0_win) begin
      mem_addr_o  = m0_addr_i;
      mem_we_o    = m0_we_i;
      mem_wdata_o = m0_wdata_i;
    end else if (m1_win) begin
      mem_addr_o  = m1_addr_i;
      mem_we_o    = m1_we_i;
      mem_wdata_o = m1_wdata_i;
    end
  end

  assign m0_gnt_o    = m0_win;
  assign m1_gnt_o    = m1_win;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign busy_o      = (state_q == LOCK);

endmodule : dpram_arbiter

// File: tb/tb_dpram_arbiter.sv
// Self-checking bench for dpram_arbiter: a word-array RAM, a behavioural
// reference of the arbitration rules checked every cycle, and directed
// scenarios with literal expectations.
module tb_dpram_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXL = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  dpram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_LOCK   (MAXL),
    .LOCK_CNT_W (CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_lock_i   (m1_lock),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy)
  );

  // RAM seen by the DUT: word-addressed, combinational read, write at edge.
  logic [DW-1:0] ram [256] = '{default: '0};
  assign mem_rdata = ram[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- reference model ----------------
  bit            mdl_init = 1'b0;
  bit            mdl_locked;
  int            mdl_beats;
  int            mdl_last;
  bit            mdl_rv0, mdl_rv1;
  logic [DW-1:0] mdl_rd0, mdl_rd1;
  logic [DW-1:0] ref_mem [256] = '{default: '0};

  // Winner for the present inputs: -1 none, 0 = M0, 1 = M1.
  function automatic int pick();
    if (!rst_n) return -1;
    if (mdl_locked && m1_req && m1_lock)
      return (mdl_beats < MAXL || !m0_req) ? 1 : 0;
    if (m0_req && m1_req) return (mdl_last == 0) ? 1 : 0;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model_update
    int w;
    w = pick();
    if (!rst_n) begin
      mdl_init   <= 1'b1;
      mdl_locked <= 1'b0;
      mdl_beats  <= 0;
      mdl_last   <= 1;
      mdl_rv0    <= 1'b0;
      mdl_rv1    <= 1'b0;
      mdl_rd0    <= '0;
      mdl_rd1    <= '0;
    end else begin
      mdl_rv0 <= (w == 0) && !m0_we;
      mdl_rv1 <= (w == 1) && !m1_we;
      if (w == 0 && !m0_we) mdl_rd0 <= ref_mem[m0_addr[9:2]];
      if (w == 1 && !m1_we) mdl_rd1 <= ref_mem[m1_addr[9:2]];
      if (w == 0 && m0_we) ref_mem[m0_addr[9:2]] <= m0_wdata;
      if (w == 1 && m1_we) ref_mem[m1_addr[9:2]] <= m1_wdata;
      if (w >= 0) mdl_last <= w;
      if (w == 1 && m1_lock) begin
        mdl_locked <= 1'b1;
        mdl_beats  <= !mdl_locked ? 1 : (mdl_beats < MAXL ? mdl_beats + 1 : MAXL);
      end else begin
        mdl_locked <= 1'b0;
        mdl_beats  <= 0;
      end
    end
  end

  // Compare DUT against the model mid-cycle, once inputs have settled.
  always @(negedge clk) begin : model_compare
    int w;
    if (mdl_init) begin
      w = pick();
      check_b("m0_gnt", m0_gnt, w == 0);
      check_b("m1_gnt", m1_gnt, w == 1);
      check_b("mem_we", mem_we, (w == 0) ? m0_we : (w == 1) ? m1_we : 1'b0);
      check_b("busy", busy, mdl_locked);
      if (rst_n) begin
        check("mem_addr", mem_addr, (w == 0) ? m0_addr : (w == 1) ? m1_addr : 32'h0);
        check("mem_wdata", mem_wdata, (w == 0) ? m0_wdata : (w == 1) ? m1_wdata : 32'h0);
        check_b("m0_rvalid", m0_rvalid, mdl_rv0);
        check_b("m1_rvalid", m1_rvalid, mdl_rv1);
        check("m0_rdata", m0_rdata, mdl_rd0);
        check("m1_rdata", m1_rdata, mdl_rd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic l1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    logic [1:0] got;
    logic [1:0] exp2;

    do_reset();
    #2;
    check_b("reset_m0_rvalid", m0_rvalid, 1'b0);
    check_b("reset_m1_rvalid", m1_rvalid, 1'b0);
    check("reset_m0_rdata", m0_rdata, 32'h0);
    check("reset_m1_rdata", m1_rdata, 32'h0);
    check_b("reset_busy", busy, 1'b0);

    // M0 write then read back the same word.
    set_in(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 check_b("t1_wr_gnt", m0_gnt, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 check_b("t1_rd_gnt", m0_gnt, 1'b1);
    check_b("t1_no_rvalid_after_write", m0_rvalid, 1'b0);
    tick();
    idle();
    #2 check_b("t1_rvalid", m0_rvalid, 1'b1);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    check_b("t1_m1_rvalid", m1_rvalid, 1'b0);
    tick();
    #2 check_b("t1_rvalid_one_cycle", m0_rvalid, 1'b0);
    check("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // Preload a word for M1, then contend from reset: M0,M1,M0,M1.
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
    tick();
    do_reset();
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #2;
      got  = {m1_gnt, m0_gnt};
      exp2 = (i % 2 == 1) ? 2'b10 : 2'b01;
      check("t2_alternate_gnt", {30'b0, got}, {30'b0, exp2});
      if (i > 0) begin
        check_b("t2_m0_rvalid", m0_rvalid, (i % 2 == 1));
        check_b("t2_m1_rvalid", m1_rvalid, (i % 2 == 0));
      end
      tick();
    end
    idle();
    #2 check_b("t2_last_m1_rvalid", m1_rvalid, 1'b1);
    check("t2_m1_rdata", m1_rdata, 32'hCAFEF00D);
    check("t2_m0_rdata", m0_rdata, 32'hDEADBEEF);
    tick();

    // 12-beat locked M1 write burst, M0 idle: never released.
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'(i));
      #2 check_b("t3_m1_gnt", m1_gnt, 1'b1);
      check_b("t3_busy", busy, (i > 0));
      tick();
    end
    idle();
    #2 check_b("t3_busy_until_edge", busy, 1'b1);
    tick();
    #2 check_b("t3_released", busy, 1'b0);

    // Locked burst with M0 joining at beat 3: M1 x8, M0, then M1 again.
    for (int c = 1; c <= 10; c++) begin
      set_in((c >= 3), 1'b1, 32'h300, 32'h5A5A0000, 1'b1, 1'b1, 1'b1,
             32'h200 + 32'(4 * c), 32'h1000 + 32'(c));
      #2;
      got  = {m1_gnt, m0_gnt};
      exp2 = (c == 9) ? 2'b01 : 2'b10;
      check("t4_cap_gnt", {30'b0, got}, {30'b0, exp2});
      tick();
    end
    idle();
    tick();

    // Reset while M1 holds a locked read burst.
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0);
    #2 check_b("t5_no_gnt_m0", m0_gnt, 1'b0);
    check_b("t5_no_gnt_m1", m1_gnt, 1'b0);
    check_b("t5_no_we", mem_we, 1'b0);
    tick();
    #2 check_b("t5_m1_rvalid_dropped", m1_rvalid, 1'b0);
    check_b("t5_busy_cleared", busy, 1'b0);
    check_b("t5_still_no_gnt", m1_gnt, 1'b0);
    tick();
    rst_n = 1'b1;
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    #2 check_b("t5_post_reset_m0_first", m0_gnt, 1'b1);
    check_b("t5_post_reset_m1_wait", m1_gnt, 1'b0);
    tick();
    idle();
    tick();

    // M1 drops lock mid-burst while M0 waits: M0 wins in that same cycle.
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h11);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h22);
    tick();
    set_in(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 32'h48, 32'h33);
    #2 check_b("t6_m0_gnt_on_unlock", m0_gnt, 1'b1);
    check_b("t6_m1_waits", m1_gnt, 1'b0);
    tick();
    idle();
    #2 check_b("t6_back_to_arb", busy, 1'b0);
    check_b("t6_m0_rvalid", m0_rvalid, 1'b1);
    check("t6_m0_rdata", m0_rdata, 32'h11);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dpram_arbiter
